// File: rtl/f_pc_unit.sv
// ----------------------------------------------------------------------------
// f_pc_unit
//
// Fetch-side program counter and F/D pipeline register for the five-stage
// MIPS core. Holds the fetch PC, computes the next PC from the D-stage
// next-PC selection (delayed-branch semantics: the slot instruction already
// in F always proceeds into D; there is no flush), and latches the fetched
// instruction together with its PC into D. A stall freezes every register.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   stall       hazard unit: hold f_pc_q, d_pc_q, d_instr_q
//   npc_op      D-stage next-PC select (0 PC4, 1 BRANCH, 2 J, 3 JR, 4-7 PC4)
//   jump        D-stage comparator result, used only for BRANCH
//   d_imm16     branch offset field of the D instruction
//   d_imm26     jump index field of the D instruction
//   d_rs_data   forwarded rs value for JR
//   f_instr     instruction memory read data at f_pc
//   f_pc        current fetch PC (instruction memory address)
//   d_pc        PC of the instruction held in D
//   d_instr     instruction held in D
//   d_pc_plus8  link value (d_pc + 8)
//   f_pc_oob    f_pc outside instruction memory or not word aligned
//   redirect    next PC is not f_pc + 4 this cycle
// ----------------------------------------------------------------------------
module f_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [2:0]  npc_op,
   input  logic        jump,
   input  logic [15:0] d_imm16,
   input  logic [25:0] d_imm26,
   input  logic [31:0] d_rs_data,
   input  logic [31:0] f_instr,
   output logic [31:0] f_pc,
   output logic [31:0] d_pc,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc_plus8,
   output logic        f_pc_oob,
   output logic        redirect
);

   localparam logic [2:0] NPC_PC4    = 3'd0;
   localparam logic [2:0] NPC_BRANCH = 3'd1;
   localparam logic [2:0] NPC_J      = 3'd2;
   localparam logic [2:0] NPC_JR     = 3'd3;

   // End of instruction memory computed in 33 bits so a region touching the
   // top of the address space does not wrap to a small value.
   localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

   logic [31:0] f_pc_q;
   logic [31:0] d_pc_q;
   logic [31:0] d_instr_q;

   logic [31:0] f_pc_plus4;
   logic [31:0] d_pc_plus4;
   logic [31:0] branch_off;
   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;
   logic [31:0] next_pc;
   logic        take_redirect;

   assign f_pc_plus4 = f_pc_q + 32'd4;
   assign d_pc_plus4 = d_pc_q + 32'd4;

   // Branch offset: sign-extended word offset relative to the slot address.
   assign branch_off = {{14{d_imm16[15]}}, d_imm16, 2'b00};
   assign branch_tgt = d_pc_plus4 + branch_off;
   assign jump_tgt   = {d_pc_plus4[31:28], d_imm26, 2'b00};

   // jump feeds straight into the next-PC mux; it is the critical path, so it
   // is kept as the last select rather than folded into npc_op decoding.
   always_comb begin
      next_pc       = f_pc_plus4;
      take_redirect = 1'b0;
      case (npc_op)
         NPC_BRANCH: begin
            if (jump) begin
               next_pc       = branch_tgt;
               take_redirect = 1'b1;
            end
         end
         NPC_J: begin
            next_pc       = jump_tgt;
            take_redirect = 1'b1;
         end
         NPC_JR: begin
            next_pc       = d_rs_data;
            take_redirect = 1'b1;
         end
         default: begin
            next_pc       = f_pc_plus4;
            take_redirect = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_pc_q    <= RESET_PC;
         d_pc_q    <= 32'd0;
         d_instr_q <= 32'd0;
      end else if (!stall) begin
         f_pc_q    <= next_pc;
         d_pc_q    <= f_pc_q;
         d_instr_q <= f_instr;
      end
   end

   // A stalled cycle does not take the redirect; D re-evaluates next cycle.
   assign redirect   = !stall && take_redirect;

   assign f_pc       = f_pc_q;
   assign d_pc       = d_pc_q;
   assign d_instr    = d_instr_q;
   assign d_pc_plus8 = d_pc_q + 32'd8;

   assign f_pc_oob   = ({1'b0, f_pc_q} <  {1'b0, IM_BASE}) ||
                       ({1'b0, f_pc_q} >= IM_END)          ||
                       (f_pc_q[1:0] != 2'b00);

endmodule
